// File: rtl/cla_pkg.sv
// Shared configuration for the pipelined carry-look-ahead adder: defaults,
// stage payload layout and the WIDTH/GROUP legality check.
package cla_pkg;

   localparam int unsigned CLA_WIDTH = 16;
   localparam int unsigned CLA_GROUP = 4;

   // Payload carried by each pipeline stage at the default configuration.
   typedef struct packed {
      logic [CLA_WIDTH-1:0] psum;
      logic [CLA_WIDTH-1:0] a_rem;
      logic [CLA_WIDTH-1:0] b_rem;
      logic                 carry;
      logic                 c_msb;
      logic                 valid;
   } cla_stage_t;

   function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned group);
      return (group != 0) && (width >= group) && ((width % group) == 0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit look-ahead slice: every internal carry is a flat
// sum-of-products of generate/propagate terms, with no ripple inside the group.
module cla_group
   import cla_pkg::*;
#(
   parameter int unsigned GROUP = CLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_p;
   logic [GROUP:0]   w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // c[i+1] = ci&p[0..i] | sum over j of g[j]&p[j+1..i]
   always_comb begin
      logic w_acc;
      logic w_term;
      w_acc  = 1'b0;
      w_term = 1'b0;
      w_c    = '0;
      w_c[0] = ci;
      for (int unsigned i = 0; i < GROUP; i++) begin
         w_acc = ci;
         for (int unsigned j = 0; j <= i; j++) begin
            w_acc = w_acc & w_p[j];
         end
         for (int unsigned j = 0; j <= i; j++) begin
            w_term = w_g[j];
            for (int unsigned m = j + 1; m <= i; m++) begin
               w_term = w_term & w_p[m];
            end
            w_acc = w_acc | w_term;
         end
         w_c[i+1] = w_acc;
      end
   end

   assign s     = w_p ^ w_c[GROUP-1:0];
   assign co    = w_c[GROUP];
   assign c_msb = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder: one GROUP-bit slice per stage, carry passed stage to stage,
// valid/ready on both sides. Define CLA_SUB_EN to add the sub (subtract) input.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH,
   parameter int unsigned GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NSTG = WIDTH / GROUP;

   if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_cfg_err
      $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
   end

   // Same layout as cla_stage_t, sized by this instance's WIDTH.
   typedef struct packed {
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic             carry;
      logic             c_msb;
      logic             valid;
   } stage_t;

   stage_t           r_stg [NSTG];
   stage_t           w_nxt [NSTG];
   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

`ifdef CLA_SUB_EN
   assign w_b_eff   = b ^ {WIDTH{sub}};
   assign w_cin_eff = cin ^ sub;
`else
   assign w_b_eff   = b;
   assign w_cin_eff = cin;
`endif

   assign w_adv    = !r_stg[NSTG-1].valid || out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [WIDTH-1:0] w_a_in;
      logic [WIDTH-1:0] w_b_in;
      logic [WIDTH-1:0] w_psum_in;
      logic [WIDTH-1:0] w_psum;
      logic [GROUP-1:0] w_s;
      logic             w_c_in;
      logic             w_v_in;
      logic             w_co;
      logic             w_cmsb;

      if (k == 0) begin : g_head
         assign w_a_in    = a;
         assign w_b_in    = w_b_eff;
         assign w_c_in    = w_cin_eff;
         assign w_psum_in = '0;
         assign w_v_in    = in_valid;
      end else begin : g_body
         assign w_a_in    = r_stg[k-1].a_rem;
         assign w_b_in    = r_stg[k-1].b_rem;
         assign w_c_in    = r_stg[k-1].carry;
         assign w_psum_in = r_stg[k-1].psum;
         assign w_v_in    = r_stg[k-1].valid;
      end

      cla_group #(.GROUP(GROUP)) u_group (
         .a     (w_a_in[GROUP*k +: GROUP]),
         .b     (w_b_in[GROUP*k +: GROUP]),
         .ci    (w_c_in),
         .s     (w_s),
         .co    (w_co),
         .c_msb (w_cmsb)
      );

      always_comb begin
         w_psum                    = w_psum_in;
         w_psum[GROUP*k +: GROUP]  = w_s;
      end

      assign w_nxt[k] = '{psum:  w_psum,
                          a_rem: w_a_in,
                          b_rem: w_b_in,
                          carry: w_co,
                          c_msb: w_cmsb,
                          valid: w_v_in};
   end

   // Bubbles shift like data; the whole pipe freezes on a stalled output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NSTG; i++) begin
            r_stg[i] <= '0;
         end
      end else if (w_adv) begin
         r_stg <= w_nxt;
      end
   end

   assign sum       = r_stg[NSTG-1].psum;
   assign cout      = r_stg[NSTG-1].carry;
   assign ovf       = r_stg[NSTG-1].carry ^ r_stg[NSTG-1].c_msb;
   assign out_valid = r_stg[NSTG-1].valid;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=16, GROUP=4); subtract vectors
// run only when CLA_SUB_EN is defined.
module tb_cla_pipe_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
`ifdef CLA_SUB_EN
   logic        sub;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_q [$];
   int          n_out;
   int          first_cyc;
   int          last_cyc;
   int          cyc;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer addition, ovf from operand/result sign bits.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [15:0] yy;
      logic [16:0] r;
      logic        v;
      yy = y ^ {16{s}};
      r  = {1'b0, x} + {1'b0, yy} + {16'b0, c ^ s};
      v  = (x[15] == yy[15]) && (r[15] != x[15]);
      return {v, r[16], r[15:0]};
   endfunction

   task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec, input logic eo);
      int n;
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
`ifdef CLA_SUB_EN
      sub = ts;
`else
      if (ts) $error("FAIL %s sub requested without CLA_SUB_EN", tag);
`endif
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 32'd4);
      chk({tag, "_sum"},  {16'b0, sum},  {16'b0, es});
      chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
      chk({tag, "_ovf"},  {31'b0, ovf},  {31'b0, eo});
      tick();
   endtask

   task automatic sample_stream();
      logic [17:0] e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("stream_extra", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("stream_sum",  {16'b0, sum},  {16'b0, e[15:0]});
            chk("stream_cout", {31'b0, cout}, {31'b0, e[16]});
            chk("stream_ovf",  {31'b0, ovf},  {31'b0, e[17]});
            n_out++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
      end
   endtask

   initial begin
      int g;
      logic [17:0] e;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SUB_EN
      sub = 1'b0;
`endif

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum",       {16'b0, sum},       32'd0);
      chk("rst_cout",      {31'b0, cout},      32'd0);
      chk("rst_ovf",       {31'b0, ovf},       32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Directed single operations
      run_one("single",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_one("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("cin_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Streaming: 64 back-to-back random pairs
      n_out = 0; first_cyc = -1; last_cyc = -1; cyc = 0;
      for (int i = 0; i < 64; i++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         exp_q.push_back(model(a, b, cin, 1'b0));
         tick();
         cyc++;
         sample_stream();
      end
      in_valid = 1'b0;
      g = 0;
      while (exp_q.size() > 0 && g < 20) begin
         tick();
         cyc++;
         g++;
         sample_stream();
      end
      chk("stream_count", n_out, 32'd64);
      chk("stream_span",  last_cyc - first_cyc, 32'd63);
      tick();

      // Backpressure with the pipe full
      exp_q.delete();
      exp_q.push_back({1'b0, 1'b0, 16'h2345});
      exp_q.push_back({1'b0, 1'b1, 16'h0000});
      exp_q.push_back({1'b1, 1'b0, 16'h8000});
      exp_q.push_back({1'b0, 1'b1, 16'h0000});
      a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; tick();
      a = 16'hFFFF; b = 16'h0001; cin = 1'b0; tick();
      a = 16'h4000; b = 16'h4000; cin = 1'b0; tick();
      a = 16'h0F0F; b = 16'hF0F0; cin = 1'b1; tick();
      out_ready = 1'b0;
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
      #1;
      chk("bp_in_ready_now", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_valid",    {31'b0, out_valid}, 32'd1);
         chk("bp_hold_sum",      {16'b0, sum},       32'h2345);
         chk("bp_hold_in_ready", {31'b0, in_ready},  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      g = 0;
      while (exp_q.size() > 0 && g < 8) begin
         e = exp_q.pop_front();
         chk("bp_drain_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_drain_sum",   {16'b0, sum},       {16'b0, e[15:0]});
         chk("bp_drain_cout",  {31'b0, cout},      {31'b0, e[16]});
         chk("bp_drain_ovf",   {31'b0, ovf},       {31'b0, e[17]});
         tick();
         g++;
      end
      chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset with operations in flight
      a = 16'h8000; b = 16'h8001; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_pre_valid", {31'b0, out_valid}, 32'd1);
      chk("mid_pre_sum",   {16'b0, sum},       32'h0001);
      chk("mid_pre_cout",  {31'b0, cout},      32'd1);
      chk("mid_pre_ovf",   {31'b0, ovf},       32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid",    {31'b0, out_valid}, 32'd0);
      chk("mid_rst_sum",      {16'b0, sum},       32'd0);
      chk("mid_rst_cout",     {31'b0, cout},      32'd0);
      chk("mid_rst_ovf",      {31'b0, ovf},       32'd0);
      chk("mid_rst_in_ready", {31'b0, in_ready},  32'd1);
      a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_no_stale", {31'b0, out_valid}, 32'd0);
      end

`ifdef CLA_SUB_EN
      run_one("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub_no_borrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      sub = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
